// File: rtl/call_stack_pkg.sv
// Shared word width, stack depth and operation decode for the call/return stack.
// Keeps the PC, register file and stack in agreement on the datapath word width.
package call_stack_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int STACK_DEPTH = 16;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_CLR,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } stack_op_e;

    // clr wins; push+pop on a non-empty stack replaces the top; on an empty stack it is a push.
    function automatic stack_op_e decode_op(input logic push, input logic pop,
                                            input logic clr, input logic empty);
        if (clr)                   return OP_CLR;
        if (push && pop && !empty) return OP_REPLACE;
        if (push)                  return OP_PUSH;
        if (pop)                   return OP_POP;
        return OP_IDLE;
    endfunction

endpackage

// File: rtl/call_stack_stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port and one asynchronous read port.
// Write takes effect at posedge; read is combinational. There is no backpressure.
module stack_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware LIFO for jal/jst and lstk/sstk, with a show-ahead top of stack and sticky over/underflow flags.
// Reads have zero latency and writes land at posedge; refused operations only set a flag and never stall.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             we;
    logic [AW-1:0]    wr_idx, top_idx, waddr;
    logic [WIDTH-1:0] rdata;
    stack_op_e        op;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign wr_idx  = count_q[AW-1:0];
    // When full, wr_idx is 0 and the subtraction wraps to DEPTH-1, which is the real top.
    assign top_idx = wr_idx - AW'(1);
    assign op      = decode_op(push, pop, clr, empty);

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we      = 1'b0;
        waddr   = wr_idx;
        unique case (op)
            OP_CLR: begin
                count_d = '0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
            end
            OP_REPLACE: begin
                we    = 1'b1;
                waddr = top_idx;
            end
            OP_PUSH: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    count_d = count_q + CNT_ONE;
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (data_in),
        .raddr (top_idx),
        .rdata (rdata)
    );

    assign data_out  = empty ? '0 : rdata;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: strobes change on negedge, outputs are sampled 1ns after posedge.
module tb_call_stack;

    logic        clk;
    logic        reset;
    logic        push;
    logic        pop;
    logic        clr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    call_stack #(.WIDTH(32), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clr       (clr),
        .data_in   (data_in),
        .data_out  (data_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic pu, input logic po, input logic cl, input logic [31:0] d);
        @(negedge clk);
        push    = pu;
        pop     = po;
        clr     = cl;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_data", data_out, 32'h0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_unf", 32'(underflow), 32'd0);

        // LIFO order with show-ahead top
        op(1'b1, 1'b0, 1'b0, 32'h10);
        chk("push1_data", data_out, 32'h10);
        op(1'b1, 1'b0, 1'b0, 32'h20);
        op(1'b1, 1'b0, 1'b0, 32'h30);
        chk("push3_count", 32'(count), 32'd3);
        chk("push3_data", data_out, 32'h30);
        op(1'b0, 1'b1, 1'b0, 32'h0);
        chk("pop_data", data_out, 32'h20);
        chk("pop_count", 32'(count), 32'd2);

        // Replace top with simultaneous push and pop
        op(1'b1, 1'b1, 1'b0, 32'h99);
        chk("repl_count", 32'(count), 32'd2);
        chk("repl_data", data_out, 32'h99);
        op(1'b0, 1'b1, 1'b0, 32'h0);
        chk("repl_pop_data", data_out, 32'h10);
        chk("repl_pop_count", 32'(count), 32'd1);
        op(1'b0, 1'b1, 1'b0, 32'h0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_unf", 32'(underflow), 32'd0);

        // Underflow, then clr
        op(1'b0, 1'b1, 1'b0, 32'h0);
        chk("unf_count", 32'(count), 32'd0);
        chk("unf_data", data_out, 32'h0);
        chk("unf_flag", 32'(underflow), 32'd1);
        op(1'b1, 1'b0, 1'b0, 32'h77);
        chk("after_unf_push", data_out, 32'h77);
        chk("unf_sticky", 32'(underflow), 32'd1);
        op(1'b0, 1'b0, 1'b1, 32'h0);
        chk("clr_unf", 32'(underflow), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_count", 32'(count), 32'd0);

        // push+pop on empty acts as a plain push
        op(1'b1, 1'b1, 1'b0, 32'h44);
        chk("pp_empty_count", 32'(count), 32'd1);
        chk("pp_empty_data", data_out, 32'h44);
        op(1'b0, 1'b0, 1'b1, 32'h0);

        // Fill to DEPTH, then overflow
        for (int i = 1; i <= 16; i++) begin
            op(1'b1, 1'b0, 1'b0, 32'(i));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_data", data_out, 32'd16);
        op(1'b1, 1'b0, 1'b0, 32'hDEAD);
        chk("ovf_count", 32'(count), 32'd16);
        chk("ovf_data", data_out, 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        op(1'b1, 1'b1, 1'b0, 32'h55);
        chk("full_repl_count", 32'(count), 32'd16);
        chk("full_repl_data", data_out, 32'h55);
        op(1'b0, 1'b1, 1'b0, 32'h0);
        chk("full_pop_data", data_out, 32'd15);
        chk("full_pop_full", 32'(full), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        op(1'b0, 1'b0, 1'b1, 32'h0);
        chk("clr2_empty", 32'(empty), 32'd1);
        chk("clr2_ovf", 32'(overflow), 32'd0);

        // Asynchronous reset between posedges
        op(1'b1, 1'b0, 1'b0, 32'hA);
        op(1'b1, 1'b0, 1'b0, 32'hB);
        op(1'b1, 1'b0, 1'b0, 32'hC);
        chk("pre_rst_count", 32'(count), 32'd3);
        reset = 1'b0;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_data", data_out, 32'h0);
        @(negedge clk);
        push  = 1'b0;
        reset = 1'b1;
        op(1'b1, 1'b0, 1'b0, 32'h5);
        chk("post_rst_data", data_out, 32'h5);
        chk("post_rst_count", 32'(count), 32'd1);

        op(1'b0, 1'b0, 1'b0, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
